// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the 5-stage pipeline hazard sequencer.
//   - FSM state encodings (RUN / FLUSH / MEM_WAIT)
//   - register-index width and the hard-wired zero register
//   - packed pipeline-control bundle and its canned values
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Flush down-counter width; FLUSH_CYCLES is limited to 1..7.
    localparam int FLUSH_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_stall;
        logic idex_hold;
        logic exmem_hold;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = ctrl_t'(7'b1100000); // everything advances
    localparam ctrl_t CTRL_FLUSH  = ctrl_t'(7'b1111000); // IF/ID loads a NOP, ID/EX bubble
    localparam ctrl_t CTRL_LDUSE  = ctrl_t'(7'b0001000); // front end holds, bubble into EX
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b0000111); // whole pipe frozen behind MEM
    localparam ctrl_t CTRL_RESET  = ctrl_t'(7'b0011001); // safe values while in reset

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline-control bus between the datapath and the hazard sequencer.
//   master : datapath side (drives hazard inputs, receives control)
//   slave  : sequencer side
// Inputs : id_rs/id_rt/id_uses_rt (ID sources), ex_memRead/ex_rt (load in EX),
//          ex_branch_taken, mem_req/mem_ready (data memory), perf_clr
// Outputs: pc_write, ifid_write, ifid_flush, idex_stall, idex_hold,
//          exmem_hold, memwb_bubble, mem_err, state, stall_cnt
interface hazard_sequencer_if #(
    parameter int PERF_W = 16
);
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rt;
    logic              ex_memRead;
    logic [REG_W-1:0]  ex_rt;
    logic              ex_branch_taken;
    logic              mem_req;
    logic              mem_ready;
    logic              perf_clr;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_stall;
    logic              idex_hold;
    logic              exmem_hold;
    logic              memwb_bubble;
    logic              mem_err;
    logic [1:0]        state;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memRead, ex_rt, ex_branch_taken,
               mem_req, mem_ready, perf_clr,
        input  pc_write, ifid_write, ifid_flush, idex_stall, idex_hold,
               exmem_hold, memwb_bubble, mem_err, state, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memRead, ex_rt, ex_branch_taken,
               mem_req, mem_ready, perf_clr,
        output pc_write, ifid_write, ifid_flush, idex_stall, idex_hold,
               exmem_hold, memwb_bubble, mem_err, state, stall_cnt
    );

endinterface

// File: rtl/hazard_sequencer_load_use_detect.sv
// Combinational load-use comparator: flags when the instruction in ID
// sources the register a load in EX is about to write.
//   id_rs_i, id_rt_i, id_uses_rt_i : source fields of the ID instruction
//   ex_mem_read_i, ex_rt_i         : load in EX and its destination
//   hit_o                          : load-use hazard present
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    output logic             hit_o
);

    // $zero is never a real dependency.
    assign hit_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                   ((id_rs_i == ex_rt_i) || (id_uses_rt_i && (id_rt_i == ex_rt_i)));

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer for the 5-stage MIPS core. Every cycle it
// decides whether each pipeline register advances, holds, flushes or takes
// a bubble. Handles memory waits (with timeout), taken-branch flushes and
// load-use stalls, in that priority order. Outputs are Mealy.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hazard_sequencer_if.slave (hazard inputs, control outputs,
//                sticky mem_err, FSM state, stall-cycle counter)
module hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int PERF_W       = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_sequencer_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [FLUSH_W-1:0] FLUSH_ALL = FLUSH_W'(FLUSH_CYCLES);

    state_e             state_q, state_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               defer_q, defer_d;   // branch taken while entering MEM_WAIT
    logic               mem_err_q, mem_err_d;
    logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;

    ctrl_t ctrl;
    logic  lu_hit;
    logic  mem_wait;

    assign mem_wait = bus.mem_req && !bus.mem_ready;

    load_use_detect u_lud (
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .id_uses_rt_i  (bus.id_uses_rt),
        .ex_mem_read_i (bus.ex_memRead),
        .ex_rt_i       (bus.ex_rt),
        .hit_o         (lu_hit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            defer_q     <= 1'b0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            defer_q     <= defer_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        defer_d     = defer_q;
        mem_err_d   = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                    defer_d    = bus.ex_branch_taken;
                end else if (bus.ex_branch_taken && FLUSH_CYCLES > 1) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (mem_wait) begin
                    // Remaining flush cycles survive the wait.
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                    if (flush_cnt_q <= FLUSH_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    wait_cnt_d = '0;
                    defer_d    = 1'b0;
                    if (defer_q) begin
                        // The whole branch flush still has to happen.
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_ALL;
                    end else if (flush_cnt_q != '0) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (wait_cnt_q == WAIT_MAX) begin
                    // Abort: drop any pending flush work along with the access.
                    mem_err_d   = 1'b1;
                    state_d     = ST_RUN;
                    wait_cnt_d  = '0;
                    flush_cnt_d = '0;
                    defer_d     = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
                wait_cnt_d  = '0;
                defer_d     = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ctrl = CTRL_RUN;
        case (state_q)
            ST_RUN: begin
                if (mem_wait)                 ctrl = CTRL_FREEZE;
                else if (bus.ex_branch_taken) ctrl = CTRL_FLUSH;   // load-use victim is flushed anyway
                else if (lu_hit)              ctrl = CTRL_LDUSE;
            end
            ST_FLUSH:    ctrl = mem_wait ? CTRL_FREEZE : CTRL_FLUSH;
            ST_MEM_WAIT: ctrl = bus.mem_ready ? CTRL_RUN : CTRL_FREEZE;
            default:     ctrl = CTRL_RUN;
        endcase
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end
    end

    // Stall-cycle counter: clear beats increment, saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.perf_clr) begin
            stall_cnt_d = '0;
        end else if (!ctrl.pc_write && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.ifid_write   = ctrl.ifid_write;
    assign bus.ifid_flush   = ctrl.ifid_flush;
    assign bus.idex_stall   = ctrl.idex_stall;
    assign bus.idex_hold    = ctrl.idex_hold;
    assign bus.exmem_hold   = ctrl.exmem_hold;
    assign bus.memwb_bubble = ctrl.memwb_bubble;
    assign bus.mem_err      = mem_err_q;
    assign bus.state        = state_q;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed, table-driven bench for hazard_sequencer. Instance A
// (FLUSH_CYCLES=2, MEM_TIMEOUT=8, PERF_W=16) runs the vector table; instance
// B (FLUSH_CYCLES=1, MEM_TIMEOUT=3, PERF_W=4) covers timeout and saturation.
module tb_hazard_sequencer;
    import pipe_ctrl_pkg::*;

    // Control bits: {pc_write, ifid_write, ifid_flush, idex_stall, idex_hold, exmem_hold, memwb_bubble}
    localparam logic [6:0] C_RUN = 7'b1100000;
    localparam logic [6:0] C_LU  = 7'b0001000;
    localparam logic [6:0] C_FL  = 7'b1111000;
    localparam logic [6:0] C_FRZ = 7'b0000111;
    localparam logic [6:0] C_RST = 7'b0011001;
    localparam logic [6:0] M_ALL = 7'b1111111;
    localparam logic [6:0] M_FL  = 7'b1011111;  // ifid_write not checked during flush

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memRead, ex_branch_taken, mem_req, mem_ready, perf_clr;

    hazard_sequencer_if #(.PERF_W(16)) ifa ();
    hazard_sequencer_if #(.PERF_W(4))  ifb ();

    assign ifa.id_rs = id_rs;                     assign ifb.id_rs = id_rs;
    assign ifa.id_rt = id_rt;                     assign ifb.id_rt = id_rt;
    assign ifa.id_uses_rt = id_uses_rt;           assign ifb.id_uses_rt = id_uses_rt;
    assign ifa.ex_memRead = ex_memRead;           assign ifb.ex_memRead = ex_memRead;
    assign ifa.ex_rt = ex_rt;                     assign ifb.ex_rt = ex_rt;
    assign ifa.ex_branch_taken = ex_branch_taken; assign ifb.ex_branch_taken = ex_branch_taken;
    assign ifa.mem_req = mem_req;                 assign ifb.mem_req = mem_req;
    assign ifa.mem_ready = mem_ready;             assign ifb.mem_ready = mem_ready;
    assign ifa.perf_clr = perf_clr;               assign ifb.perf_clr = perf_clr;

    hazard_sequencer #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(8), .PERF_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    hazard_sequencer #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(3), .PERF_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    wire [6:0] ctrl_a = {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_stall,
                         ifa.idex_hold, ifa.exmem_hold, ifa.memwb_bubble};
    wire [6:0] ctrl_b = {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.idex_stall,
                         ifb.idex_hold, ifb.exmem_hold, ifb.memwb_bubble};

    typedef struct {
        logic [4:0] rs, rt;
        logic       ut, mr;
        logic [4:0] ert;
        logic       br, req, rdy, clr;
        logic [6:0] ctrl, msk;
        logic [1:0] st;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                                input logic mr, input logic [4:0] ert, input logic br,
                                input logic req, input logic rdy, input logic clr,
                                input logic [6:0] ctrl, input logic [6:0] msk, input logic [1:0] st);
        vec_t v;
        v.rs = rs; v.rt = rt; v.ut = ut; v.mr = mr; v.ert = ert; v.br = br;
        v.req = req; v.rdy = rdy; v.clr = clr; v.ctrl = ctrl; v.msk = msk; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                         input logic mr, input logic [4:0] ert, input logic br,
                         input logic req, input logic rdy, input logic clr);
        id_rs = rs; id_rt = rt; id_uses_rt = ut; ex_memRead = mr; ex_rt = ert;
        ex_branch_taken = br; mem_req = req; mem_ready = rdy; perf_clr = clr;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         rs  rt  ut mr ert br req rdy clr ctrl   mask   st
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, C_RUN, M_ALL, 0)); // quiet
        tv.push_back(mk(8, 2, 0, 1, 8, 0, 0, 0, 0, C_LU,  M_ALL, 0)); // rs load-use
        tv.push_back(mk(8, 2, 0, 0, 0, 0, 0, 0, 0, C_RUN, M_ALL, 0)); // bubble in EX: no second stall
        tv.push_back(mk(3, 9, 1, 1, 9, 0, 0, 0, 0, C_LU,  M_ALL, 0)); // rt load-use
        tv.push_back(mk(3, 9, 0, 1, 9, 0, 0, 0, 0, C_RUN, M_ALL, 0)); // rt not a source
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, C_RUN, M_ALL, 0)); // $zero never hazards
        tv.push_back(mk(8, 2, 0, 0, 8, 0, 0, 0, 0, C_RUN, M_ALL, 0)); // not a load
        tv.push_back(mk(8, 2, 0, 1, 8, 1, 0, 0, 0, C_FL,  M_FL,  0)); // branch beats load-use
        tv.push_back(mk(8, 2, 0, 1, 8, 0, 0, 0, 0, C_FL,  M_FL,  1)); // second flush cycle
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, C_RUN, M_ALL, 0)); // counter clear
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, C_FRZ, M_ALL, 0)); // mem wait 1
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, C_FRZ, M_ALL, 2)); // mem wait 2
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, C_FRZ, M_ALL, 2)); // mem wait 3
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, C_FRZ, M_ALL, 2)); // mem wait 4
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 1, 0, C_RUN, M_ALL, 2)); // release
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, C_RUN, M_ALL, 0)); // stall_cnt = 4 here
        tv.push_back(mk(1, 2, 0, 0, 0, 1, 1, 0, 0, C_FRZ, M_ALL, 0)); // branch + wait: defer
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, C_FRZ, M_ALL, 2));
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 1, 0, C_RUN, M_ALL, 2)); // release -> FLUSH
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, C_FL,  M_FL,  1)); // deferred flush 1
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, C_FL,  M_FL,  1)); // deferred flush 2
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, C_RUN, M_ALL, 0));
        tv.push_back(mk(1, 2, 0, 0, 0, 1, 0, 0, 0, C_FL,  M_FL,  0)); // branch
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, C_FRZ, M_ALL, 1)); // wait inside FLUSH
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 1, 0, C_RUN, M_ALL, 2)); // release -> FLUSH
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, C_FL,  M_FL,  1)); // kept flush cycle
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, C_RUN, M_ALL, 0));
        tv.push_back(mk(8, 2, 0, 1, 8, 0, 0, 0, 1, C_LU,  M_ALL, 0)); // clear beats increment
        tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, C_RUN, M_ALL, 0)); // stall_cnt = 0 here

        // Power-on reset
        idle();
        @(negedge clk);
        chk("por ctrl", ctrl_a, C_RST);
        chk("por state", ifa.state, 0);
        chk("por stall_cnt", ifa.stall_cnt, 0);
        next_cycle();
        rst_n = 1'b1;

        // Vector table on instance A
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rs, tv[i].rt, tv[i].ut, tv[i].mr, tv[i].ert, tv[i].br,
                  tv[i].req, tv[i].rdy, tv[i].clr);
            @(negedge clk);
            chk($sformatf("row%0d ctrl", i), ctrl_a & tv[i].msk, tv[i].ctrl & tv[i].msk);
            chk($sformatf("row%0d state", i), ifa.state, tv[i].st);
            chk($sformatf("row%0d mem_err", i), ifa.mem_err, 0);
            chk($sformatf("row%0d stall_cnt", i), ifa.stall_cnt, exp_cnt);
            if (tv[i].clr)              exp_cnt = 0;
            else if (!tv[i].ctrl[6])    exp_cnt++;
            next_cycle();
        end

        // Reset asserted mid-traffic for three cycles
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre-reset freeze", ctrl_a, C_FRZ);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d ctrl", k), ctrl_a, C_RST);
            chk($sformatf("rst%0d state", k), ifa.state, 0);
            chk($sformatf("rst%0d stall_cnt", k), ifa.stall_cnt, 0);
            @(negedge clk);
        end
        next_cycle();
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset pc_write", ifa.pc_write, 1);
        chk("post-reset state", ifa.state, 0);
        next_cycle();

        // Instance B: single-cycle flush stays in RUN
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b flush ctrl", ctrl_b & M_FL, C_FL & M_FL);
        next_cycle();
        idle();
        @(negedge clk);
        chk("b flush done state", ifb.state, 0);
        chk("b flush done ctrl", ctrl_b, C_RUN);
        next_cycle();

        // Instance B: memory timeout after MEM_TIMEOUT=3
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("to%0d state", k), ifb.state, (k == 0) ? 0 : 2);
            chk($sformatf("to%0d ctrl", k), ctrl_b, C_FRZ);
            chk($sformatf("to%0d mem_err", k), ifb.mem_err, 0);
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("to state back", ifb.state, 0);
        chk("to mem_err set", ifb.mem_err, 1);
        chk("to stall_cnt", ifb.stall_cnt, 4);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("mem_err sticky", ifb.mem_err, 1);
        next_cycle();

        // Instance B: 4-bit counter saturation, then clear with a stall
        drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat stall_cnt", ifb.stall_cnt, 4'hF);
        chk("sat ctrl", ctrl_b, C_LU);
        next_cycle();
        perf_clr = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        chk("clr with stall", ifb.stall_cnt, 0);

        // Reset clears the sticky error
        rst_n = 1'b0;
        #1;
        chk("mem_err cleared", ifb.mem_err, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
